instr_mem_loadable: RTL and testbench

Synchronous-read, word-organised instruction memory with a boot-load write port and a fetch request/response handshake. It is the next generation of the single-cycle processor's combinational ROM, sized for the pipelined core. A loader (testbench, UART bootloader or debug module) streams a program into it after reset. The fetch stage then reads one instruction per cycle with a fixed one-cycle latency and alignment/range fault reporting.

---
 rtl/instr_mem_loadable.sv | 117 +++++++++++
 tb/tb_instr_mem_loadable.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// Word-organised instruction memory with a streaming boot-load port
// and a registered one-cycle fetch path with alignment/range faults.
module instr_mem_loadable #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_ADDR_WIDTH = 32,
    parameter int P_DEPTH      = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_fetch_req,
    input  logic [P_ADDR_WIDTH-1:0]    i_pc,
    output logic                       o_fetch_ready,
    output logic [P_DATA_WIDTH-1:0]    o_instr,
    output logic                       o_instr_valid,
    output logic                       o_fault,
    input  logic                       i_load_start,
    input  logic                       i_load_valid,
    input  logic [P_DATA_WIDTH-1:0]    i_load_data,
    input  logic                       i_load_last,
    output logic                       o_load_ready,
    output logic                       o_load_done,
    output logic [$clog2(P_DEPTH):0]   o_load_count
);

    localparam int LW = $clog2(P_DEPTH);
    localparam logic [P_DATA_WIDTH-1:0] NOP = P_DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t                  r_state;
    logic [LW-1:0]           r_ptr;
    logic [LW:0]             r_cnt;
    logic                    r_done;
    logic [P_DATA_WIDTH-1:0] r_instr;
    logic                    r_valid;
    logic                    r_fault;
    logic [P_DATA_WIDTH-1:0] r_mem [P_DEPTH];

    logic          w_fetch;
    logic          w_beat;
    logic          w_end;
    logic          w_fault;
    logic [LW-1:0] w_idx;

    assign o_fetch_ready = (r_state == S_RUN);
    assign o_load_ready  = (r_state == S_LOAD);
    assign o_instr       = r_instr;
    assign o_instr_valid = r_valid;
    assign o_fault       = r_fault;
    assign o_load_done   = r_done;
    assign o_load_count  = r_cnt;

    assign w_fetch = i_fetch_req && o_fetch_ready;
    assign w_beat  = i_load_valid && o_load_ready;
    assign w_end   = w_beat && (i_load_last || r_ptr == LW'(P_DEPTH - 1));
    assign w_idx   = i_pc[LW+1:2];
    // Anything at or above 4*P_DEPTH has a set bit above the word index.
    assign w_fault = (i_pc[1:0] != 2'b00) || (|(i_pc >> (LW + 2)));

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge i_clk) begin
        if (w_beat) begin
            r_mem[r_ptr] <= i_load_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_valid <= w_fetch;
            if (w_fetch) begin
                r_fault <= w_fault;
                r_instr <= w_fault ? NOP : r_mem[w_idx];
            end
            unique case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_beat) begin
                        r_ptr <= r_ptr + 1'b1;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_end) begin
                        r_state <= S_RUN;
                        r_done  <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_load_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= '0;
                        r_cnt   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Bench for instr_mem_loadable: vector table of fetches, a latency-aware
// scoreboard, and hand sequences for auto-terminate, reload and reset.
module tb_instr_mem_loadable;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int D  = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] pc;
    logic          fetch_ready;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          fault;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_last;
    logic          load_ready;
    logic          load_done;
    logic [8:0]    load_count;

    always #5 clk = ~clk;

    instr_mem_loadable #(
        .P_DATA_WIDTH(DW),
        .P_ADDR_WIDTH(AW),
        .P_DEPTH     (D)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_fetch_req  (fetch_req),
        .i_pc         (pc),
        .o_fetch_ready(fetch_ready),
        .o_instr      (instr),
        .o_instr_valid(instr_valid),
        .o_fault      (fault),
        .i_load_start (load_start),
        .i_load_valid (load_valid),
        .i_load_data  (load_data),
        .i_load_last  (load_last),
        .o_load_ready (load_ready),
        .o_load_done  (load_done),
        .o_load_count (load_count)
    );

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } vec_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_done  = 0;
    int          ld_ptr  = 0;
    int          done_snap;
    exp_t        sbq[$];
    exp_t        e;
    logic [31:0] ref_mem [D];
    logic [31:0] exp_instr_d = '0;
    logic        exp_fault_d = 1'b0;
    vec_t        vec [6];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop the response first, then record a new acceptance.
    always @(negedge clk) begin
        cyc++;
        if (load_done) n_done++;
        if (instr_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("fetch_latency", cyc, e.due);
                check("fetch_instr", instr, e.instr);
                check("fetch_fault", 32'(fault), 32'(e.fault));
            end
        end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
            check("missing_valid", 32'd0, 32'd1);
            void'(sbq.pop_front());
        end
        if (fetch_req && fetch_ready && rst_n)
            sbq.push_back('{exp_instr_d, exp_fault_d, cyc + 1});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                         input logic ef);
        fetch_req   = 1'b1;
        pc          = a;
        exp_instr_d = ei;
        exp_fault_d = ef;
        tick();
    endtask

    task automatic fetch_ref(input logic [31:0] a);
        logic f;
        f = (a[1:0] != 2'b00) || (a >= 32'(4 * D));
        fetch(a, f ? 32'h0000_0013 : ref_mem[a[9:2]], f);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ld_ptr     = 0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        load_valid      = 1'b1;
        load_data       = d;
        load_last       = last;
        ref_mem[ld_ptr] = d;
        ld_ptr++;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        pc         = '0;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        vec[0] = '{32'h0,   32'h0050_0093, 1'b0};
        vec[1] = '{32'h4,   32'h0010_0113, 1'b0};
        vec[2] = '{32'h8,   32'h0020_81B3, 1'b0};
        vec[3] = '{32'hC,   32'h0000_006F, 1'b0};
        vec[4] = '{32'h6,   32'h0000_0013, 1'b1};
        vec[5] = '{32'h400, 32'h0000_0013, 1'b1};

        repeat (3) tick();
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        rst_n = 1'b1;

        // Fetches refused while IDLE.
        fetch_req = 1'b1;
        pc        = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_ready", 32'(fetch_ready), 32'd0);
            check("idle_valid", 32'(instr_valid), 32'd0);
        end
        fetch_req = 1'b0;

        // Four-word program.
        start_load();
        check("load_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 4; i++) beat(vec[i].instr, i == 3);
        check("done_pulse", 32'(load_done), 32'd1);
        check("count4", 32'(load_count), 32'd4);
        check("run_ready", 32'(fetch_ready), 32'd1);
        check("load_ready_off", 32'(load_ready), 32'd0);
        tick();
        check("done_low", 32'(load_done), 32'd0);
        check("done_once", n_done, 32'd1);

        for (int i = 0; i < 6; i++) fetch(vec[i].pc, vec[i].instr, vec[i].fault);
        fetch_req = 1'b0;
        tick();
        tick();
        check("hold_instr", instr, 32'h0000_0013);
        check("hold_valid", 32'(instr_valid), 32'd0);

        // Reload requested in the same cycle as a fetch: old word returned.
        load_start = 1'b1;
        fetch(32'h0, 32'h0050_0093, 1'b0);
        load_start = 1'b0;
        fetch_req  = 1'b0;
        ld_ptr     = 0;
        check("reload_ready", 32'(load_ready), 32'd1);
        check("reload_count0", 32'(load_count), 32'd0);
        for (int i = 0; i < D; i++) beat(32'h1000_0000 + 32'(i), 1'b0);
        check("auto_done", 32'(load_done), 32'd1);
        check("count256", 32'(load_count), 32'd256);
        check("auto_load_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b1;
        load_data  = 32'hBAD0_BAD0;
        tick();
        load_valid = 1'b0;
        check("count_held", 32'(load_count), 32'd256);
        check("auto_done_low", 32'(load_done), 32'd0);
        fetch_ref(32'h3FC);
        fetch_ref(32'h0);
        fetch_ref(32'h200);
        fetch_ref(32'h3FE);
        fetch_req = 1'b0;
        tick();
        tick();

        // Asynchronous reset in the middle of a load session.
        start_load();
        beat(32'h1111_1111, 1'b0);
        beat(32'h2222_2222, 1'b0);
        check("mid_count2", 32'(load_count), 32'd2);
        done_snap  = n_done;
        load_valid = 1'b1;
        load_data  = 32'h3333_3333;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_load_ready", 32'(load_ready), 32'd0);
        check("arst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("arst_count", 32'(load_count), 32'd0);
        load_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("arst_no_done", n_done, done_snap);

        start_load();
        beat(32'hCAFE_F00D, 1'b1);
        check("count1", 32'(load_count), 32'd1);
        tick();
        fetch_ref(32'h0);
        fetch_ref(32'h4);
        fetch_ref(32'h8);
        fetch_req = 1'b0;
        tick();
        tick();
        check("sb_drained", sbq.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
